// File: rtl/demux14_buf.sv
// demux14_buf: 1-to-4 valid/ready demultiplexer with a one-beat register per output lane.
// Each accepted input beat goes to one lane, chosen by sel or by an internal round-robin pointer.
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   in_valid/in_ready    input stream handshake (in_ready is combinational)
//   in_data[WIDTH]       input beat data
//   sel[2], auto_en      lane select / round-robin enable
//   cur_sel[2]           current target lane (combinational)
//   out_valid[4]         per-lane beat held (bit0=a .. bit3=d)
//   out_ready[4]         per-lane consumer ready
//   out_a..out_d[WIDTH]  registered lane data
module demux14_buf #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       sel,
  input  logic             auto_en,
  output logic [1:0]       cur_sel,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [WIDTH-1:0] out_c,
  output logic [WIDTH-1:0] out_d
);

  localparam int unsigned LANES = 4;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } lane_state_t;

  lane_state_t      state_q [LANES];
  lane_state_t      state_d [LANES];
  logic [WIDTH-1:0] data_q  [LANES];
  logic [1:0]       rr_ptr_q;
  logic [1:0]       rr_ptr_d;
  logic [1:0]       tgt;
  logic             accept;

  // Target lane and input handshake; a full target that is draining can still accept.
  always_comb begin
    tgt      = auto_en ? rr_ptr_q : sel;
    in_ready = !rst && ((state_q[tgt] == EMPTY) || out_ready[tgt]);
    accept   = in_valid && in_ready;
  end

  assign cur_sel = tgt;

  // Lane next-state: drain first, then a load on the target overrides to FULL.
  always_comb begin
    for (int unsigned i = 0; i < LANES; i++) begin
      state_d[i] = state_q[i];
      if ((state_q[i] == FULL) && out_ready[i]) begin
        state_d[i] = EMPTY;
      end
      if (accept && (tgt == 2'(i))) begin
        state_d[i] = FULL;
      end
    end
    rr_ptr_d = rr_ptr_q;
    if (accept && auto_en) begin
      rr_ptr_d = rr_ptr_q + 2'(1);
    end
  end

  // State, data and pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        state_q[i] <= EMPTY;
        data_q[i]  <= '0;
      end
      rr_ptr_q <= 2'd0;
    end else begin
      for (int unsigned i = 0; i < LANES; i++) begin
        state_q[i] <= state_d[i];
      end
      if (accept) begin
        data_q[tgt] <= in_data;
      end
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Outputs are straight from flops.
  always_comb begin
    for (int unsigned i = 0; i < LANES; i++) begin
      out_valid[i] = (state_q[i] == FULL);
    end
  end

  assign out_a = data_q[0];
  assign out_b = data_q[1];
  assign out_c = data_q[2];
  assign out_d = data_q[3];

endmodule

// File: tb/tb_demux14_buf.sv
// tb_demux14_buf: directed scenarios plus random traffic for demux14_buf, checked against
// a lane-array model of the demultiplexer kept in the bench.
module tb_demux14_buf;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic [1:0] sel;
  logic       auto_en;
  logic [1:0] cur_sel;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic [3:0] out_a, out_b, out_c, out_d;

  int unsigned n_pass  = 0;
  int unsigned n_fail  = 0;
  int unsigned n_total = 0;

  // Model: one flag and one data word per lane, plus the round-robin lane number.
  bit         m_valid [4];
  logic [3:0] m_data  [4];
  int         m_rr;

  always #5 clk = ~clk;

  demux14_buf #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .sel(sel), .auto_en(auto_en), .cur_sel(cur_sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_c(out_c), .out_d(out_d)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs();
    logic [3:0] ev;
    for (int i = 0; i < 4; i++) ev[i] = m_valid[i];
    chk("out_valid", 32'(out_valid), 32'(ev));
    chk("out_a", 32'(out_a), 32'(m_data[0]));
    chk("out_b", 32'(out_b), 32'(m_data[1]));
    chk("out_c", 32'(out_c), 32'(m_data[2]));
    chk("out_d", 32'(out_d), 32'(m_data[3]));
  endtask

  // One clock cycle: drive inputs, check combinational outputs, clock, update model, check registers.
  task automatic step(input logic v, input logic [3:0] d, input logic [1:0] s,
                      input logic ae, input logic [3:0] ordy, input logic r);
    int t;
    bit exp_rdy;
    bit acc;
    in_valid  = v;
    in_data   = d;
    sel       = s;
    auto_en   = ae;
    out_ready = ordy;
    rst       = r;
    #1;
    t       = ae ? m_rr : int'(s);
    exp_rdy = !r && (!m_valid[t] || ordy[t]);
    acc     = v && exp_rdy;
    chk("cur_sel", 32'(cur_sel), 32'(t));
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 4; i++) begin
        m_valid[i] = 1'b0;
        m_data[i]  = 4'h0;
      end
      m_rr = 0;
    end else begin
      for (int i = 0; i < 4; i++) if (m_valid[i] && ordy[i]) m_valid[i] = 1'b0;
      if (acc) begin
        m_valid[t] = 1'b1;
        m_data[t]  = d;
        if (ae) m_rr = (m_rr + 1) % 4;
      end
    end
    #1;
    chk_outputs();
  endtask

  initial begin
    logic [3:0] stream [5];
    stream[0] = 4'h1; stream[1] = 4'h2; stream[2] = 4'h4; stream[3] = 4'h8; stream[4] = 4'hC;
    for (int i = 0; i < 4; i++) begin
      m_valid[i] = 1'b0;
      m_data[i]  = 4'h0;
    end
    m_rr = 0;
    rst = 1'b1; in_valid = 1'b0; in_data = 4'h0; sel = 2'd0; auto_en = 1'b0; out_ready = 4'h0;
    @(posedge clk);
    #1;

    // Reset state.
    step(1'b0, 4'h0, 2'd0, 1'b0, 4'h0, 1'b1);
    step(1'b0, 4'h0, 2'd0, 1'b0, 4'h0, 1'b1);
    chk("reset_valid", 32'(out_valid), 32'h0);

    // 1: sel=2 loads lane c one cycle later.
    step(1'b1, 4'h6, 2'd2, 1'b0, 4'b0100, 1'b0);
    chk("t1_out_c", 32'(out_c), 32'h6);
    chk("t1_valid", 32'(out_valid), 32'h4);
    step(1'b0, 4'h0, 2'd0, 1'b0, 4'hF, 1'b0);

    // 2: round robin a,b,c,d,a at full rate.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, stream[i], 2'd0, 1'b1, 4'hF, 1'b0);
    end
    chk("t2_out_a", 32'(out_a), 32'hC);
    chk("t2_out_d", 32'(out_d), 32'h8);
    step(1'b0, 4'h0, 2'd0, 1'b0, 4'hF, 1'b0);

    // 3: lane b back-pressure, then release with no bubble.
    step(1'b1, 4'h3, 2'd1, 1'b0, 4'b1101, 1'b0);
    step(1'b1, 4'h9, 2'd1, 1'b0, 4'b1101, 1'b0);
    chk("t3_held", 32'(out_b), 32'h3);
    step(1'b1, 4'h9, 2'd1, 1'b0, 4'b1111, 1'b0);
    chk("t3_loaded", 32'(out_b), 32'h9);
    step(1'b0, 4'h0, 2'd0, 1'b0, 4'hF, 1'b0);

    // 4: lane d stuck full does not block a beat for lane a.
    step(1'b1, 4'h7, 2'd3, 1'b0, 4'b0111, 1'b0);
    step(1'b1, 4'h5, 2'd0, 1'b0, 4'b0111, 1'b0);
    chk("t4_out_a", 32'(out_a), 32'h5);
    chk("t4_out_d", 32'(out_d), 32'h7);
    step(1'b0, 4'h0, 2'd0, 1'b0, 4'hF, 1'b0);

    // 5: rr_ptr=2 with lanes a and c full, then reset.
    step(1'b1, 4'hA, 2'd0, 1'b1, 4'h0, 1'b0);
    step(1'b0, 4'h0, 2'd0, 1'b0, 4'b0010, 1'b0);
    step(1'b1, 4'h1, 2'd0, 1'b0, 4'h0, 1'b0);
    step(1'b1, 4'h2, 2'd2, 1'b0, 4'h0, 1'b0);
    step(1'b0, 4'h0, 2'd0, 1'b1, 4'h0, 1'b1);
    chk("t5_valid", 32'(out_valid), 32'h0);
    step(1'b1, 4'h4, 2'd2, 1'b1, 4'hF, 1'b0);
    chk("t5_lane_a", 32'(out_valid), 32'h1);

    // 6: rr_ptr=3, auto off goes to sel=1, auto on resumes at lane d.
    step(1'b1, 4'h1, 2'd0, 1'b1, 4'hF, 1'b0);
    step(1'b1, 4'h2, 2'd0, 1'b1, 4'hF, 1'b0);
    step(1'b1, 4'hE, 2'd1, 1'b0, 4'hF, 1'b0);
    chk("t6_lane_b", 32'(out_valid), 32'h2);
    step(1'b1, 4'hF, 2'd1, 1'b1, 4'hF, 1'b0);
    chk("t6_lane_d", 32'(out_valid), 32'h8);
    chk("t6_out_d", 32'(out_d), 32'hF);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(0, 3) != 0), 4'($urandom), 2'($urandom), 1'($urandom),
           4'($urandom) | 4'($urandom), 1'($urandom_range(0, 49) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
